// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, own HI/LO registers.
// Define MULDIV_SIGNED_EN to enable two's-complement MULT/DIV; otherwise op[1] is ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            is_div;
  logic [WIDTH-1:0] acc, qreg, breg, a_raw;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign a_neg = op[1] & src_a[WIDTH-1];
  assign b_neg = op[1] & src_b[WIDTH-1];
  assign mag_a = cond_neg(src_a, a_neg);
  assign mag_b = cond_neg(src_b, b_neg);
`else
  logic unused_op_sign;
  assign unused_op_sign = op[1];
  assign mag_a = src_a;
  assign mag_b = src_b;
`endif

  assign accept = start & ~flush & ((state == S_IDLE) | (state == S_DONE));
  assign busy   = (state == S_CALC) | (state == S_FIX);
  assign stall  = busy | accept;
  assign done   = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CALC;
      S_CALC: begin
        if (flush) state_nxt = S_IDLE;
        else if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE: state_nxt = accept ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end else if (state == S_CALC) begin
        cnt <= cnt + CW'(1);
      end else if (state == S_FIX && !flush && is_div && breg == '0) begin
        div_by_zero <= 1'b1;
      end
    end
  end

  // One iteration step: multiply adds then shifts {acc,qreg} right; divide shifts left then trial-subtracts.
  assign mul_sum = {1'b0, acc} + (qreg[0] ? {1'b0, breg} : '0);
  assign rem_sh  = {acc, qreg[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, breg};

  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= '0;
      qreg   <= mag_a;
      breg   <= mag_b;
      a_raw  <= src_a;
      is_div <= op[0];
`ifdef MULDIV_SIGNED_EN
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
`endif
    end else if (state == S_CALC) begin
      if (!is_div) begin
        acc  <= mul_sum[WIDTH:1];
        qreg <= {mul_sum[0], qreg[WIDTH-1:1]};
      end else if (!rem_sub[WIDTH]) begin
        acc  <= rem_sub[WIDTH-1:0];
        qreg <= {qreg[WIDTH-2:0], 1'b1};
      end else begin
        acc  <= rem_sh[WIDTH-1:0];
        qreg <= {qreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  // FIX: sign correction and commit to HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX && !flush) begin
      if (is_div && breg == '0) begin
        hi <= a_raw;
        lo <= '1;
      end else if (is_div) begin
`ifdef MULDIV_SIGNED_EN
        hi <= cond_neg(acc, neg_r);
        lo <= cond_neg(qreg, neg_q);
`else
        hi <= acc;
        lo <= qreg;
`endif
      end else begin
`ifdef MULDIV_SIGNED_EN
        {hi, lo} <= cond_neg2({acc, qreg}, neg_q);
`else
        {hi, lo} <= {acc, qreg};
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, stall, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .stall(stall), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic   sgn;
    longint sa, sb;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    z  = 1'b0;
    if (!o[0]) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      h = a;
      l = '1;
      z = 1'b1;
    end else begin
      l = W'(sa / sb);
      h = W'(sa % sb);
    end
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 check_val("stall_accept", stall, 1);
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op    = 2'($urandom);
  endtask

  // Issues one op and follows it to the done cycle; returns at the negedge of DONE.
  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int lat;
    logic [W-1:0] eh, el;
    logic ez;
    issue(o, a, b);
    check_val("dbz_clear", div_by_zero, 0);
    lat = 1;
    while (done !== 1'b1 && lat < W + 10) begin
      check_val("stall_busy", stall, 1);
      if (poke && lat == 5) begin
        start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      end
      if (poke && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    model(o, a, b, eh, el, ez);
    check_val("latency", lat, W + 2);
    check_val("busy_done", busy, 0);
    check_val("hi", hi, eh);
    check_val("lo", lo, el);
    check_val("dbz", div_by_zero, ez);
  endtask

  initial begin
    int seen;
    logic [W-1:0] h0, l0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_dbz", div_by_zero, 0);
    check_val("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_val("t1_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(negedge clk);
    run(2'b01, 32'd100, 32'd7, 1'b0);
    check_val("t2_hilo", {hi, lo}, 64'h00000002_0000000E);
    @(negedge clk);
    run(2'b11, 32'hFFFFFFF9, 32'h2, 1'b0);
    run(2'b01, 32'd5, 32'd0, 1'b0);
    check_val("t4_hilo", {hi, lo}, 64'h00000005_FFFFFFFF);
    check_val("t4_dbz", div_by_zero, 1);
    run(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run(2'b10, 32'h80000000, 32'h80000000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run(2'($urandom), pick_operand(), pick_operand(), 1'($urandom));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Flush mid-calculation
    @(negedge clk);
    run(2'b00, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_val("flush_busy", busy, 0);
    check_val("flush_stall", stall, 0);
    check_val("flush_hilo", {hi, lo}, 64'h00000000_0000000C);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_val("flush_no_done", seen, 0);

    // start with flush in IDLE is refused
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    #1 check_val("sf_idle_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("sf_idle_busy", busy, 0);

    // Flush and start in DONE: done still shown, result kept, no accept
    run(2'b01, 32'd1000, 32'd3, 1'b0);
    h0 = hi; l0 = lo;
    start = 1'b1; flush = 1'b1;
    #1;
    check_val("sf_done_stall", stall, 0);
    check_val("sf_done_done", done, 1);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("sf_done_busy", busy, 0);
    check_val("sf_done_nodone", done, 0);
    check_val("sf_done_hilo", {hi, lo}, {h0, l0});

    // Reset mid-calculation
    run(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(negedge clk);
    issue(2'b01, 32'd77, 32'd5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_hilo", {hi, lo}, 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_val("rst_mid_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
